// File: rtl/pc_writeback_path_if.sv
// rtl/pc_writeback_path_if.sv - control, datapath and writeback signals of the PC/writeback path
interface pc_writeback_path_if;
  logic        busywait;
  logic        ibusywait;
  logic        jump;
  logic        beq;
  logic        zero;
  logic [7:0]  offset;
  logic        writeenable;
  logic        writesel;
  logic [7:0]  result;
  logic [7:0]  readdata;
  logic [31:0] pc;
  logic [7:0]  writedata;
  logic        regwrite;

  // Driver side: control unit, ALU and memories
  modport master (
    output busywait, ibusywait, jump, beq, zero, offset,
    output writeenable, writesel, result, readdata,
    input  pc, writedata, regwrite
  );

  // Block side: the PC register and writeback mux
  modport slave (
    input  busywait, ibusywait, jump, beq, zero, offset,
    input  writeenable, writesel, result, readdata,
    output pc, writedata, regwrite
  );
endinterface

// File: rtl/pc_writeback_path.sv
// rtl/pc_writeback_path.sv - program counter with relative branch and register writeback select
module pc_writeback_path #(
  parameter logic [31:0] PC_RESET = 32'hFFFFFFFC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pc_writeback_path_if.slave    wb_if
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ext_offset;
  logic [31:0] branch_target;
  logic        branch_sel;
  logic        stall;

  // Next-PC selection; the stall is applied last so a stalled branch is simply retried
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    ext_offset    = {{22{wb_if.offset[7]}}, wb_if.offset, 2'b00};
    branch_target = pc_plus4 + ext_offset;
    branch_sel    = wb_if.jump | (wb_if.beq & wb_if.zero);
    stall         = wb_if.busywait | wb_if.ibusywait;
    pc_d          = branch_sel ? branch_target : pc_plus4;
    if (stall) begin
      pc_d = pc_q;
    end
  end

  // PC register; reset forces PC_RESET so the first fetch lands on address 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wb_if.pc        = pc_q;
  assign wb_if.writedata = wb_if.writesel ? wb_if.readdata : wb_if.result;
  assign wb_if.regwrite  = wb_if.writeenable & ~wb_if.busywait & ~wb_if.ibusywait;

endmodule

// File: tb/tb_pc_writeback_path.sv
// tb/tb_pc_writeback_path.sv - scoreboard bench for pc_writeback_path
module tb_pc_writeback_path;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_writeback_path_if wb ();

  pc_writeback_path dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb_if (wb)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_pc_q [$];
  logic [7:0]  exp_wd_q [$];
  logic        exp_rw_q [$];
  string       exp_nm_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  event chk_ev;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Monitor: pops and compares every queued expectation when outputs are sampled
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_pc_q.size() > 0) begin
        string       nm;
        logic [31:0] epc;
        logic [7:0]  ewd;
        logic        erw;
        nm  = exp_nm_q.pop_front();
        epc = exp_pc_q.pop_front();
        ewd = exp_wd_q.pop_front();
        erw = exp_rw_q.pop_front();
        check32({nm, ".pc"}, wb.pc, epc);
        check32({nm, ".writedata"}, {24'd0, wb.writedata}, {24'd0, ewd});
        check32({nm, ".regwrite"}, {31'd0, wb.regwrite}, {31'd0, erw});
      end
    end
  end

  task automatic set_in(input logic busy, input logic ibusy, input logic jump, input logic beq,
                        input logic zero, input logic [7:0] off, input logic we, input logic ws,
                        input logic [7:0] res, input logic [7:0] rd);
    wb.busywait    = busy;
    wb.ibusywait   = ibusy;
    wb.jump        = jump;
    wb.beq         = beq;
    wb.zero        = zero;
    wb.offset      = off;
    wb.writeenable = we;
    wb.writesel    = ws;
    wb.result      = res;
    wb.readdata    = rd;
  endtask

  task automatic push(input string nm, input logic [31:0] pc, input logic [7:0] wd, input logic rw);
    exp_nm_q.push_back(nm);
    exp_pc_q.push_back(pc);
    exp_wd_q.push_back(wd);
    exp_rw_q.push_back(rw);
  endtask

  // One clock edge with the current inputs; expectation describes state after the edge
  task automatic step(input string nm, input logic [31:0] pc, input logic [7:0] wd, input logic rw);
    @(posedge clk);
    push(nm, pc, wd, rw);
    @(negedge clk);
    #1;
  endtask

  // Expectation checked immediately, without a clock edge
  task automatic expect_now(input string nm, input logic [31:0] pc, input logic [7:0] wd, input logic rw);
    push(nm, pc, wd, rw);
    -> chk_ev;
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    #1;
    expect_now("reset", 32'hFFFFFFFC, 8'h00, 1'b0);

    set_in(0, 0, 1, 0, 0, 8'h02, 1, 0, 8'h5A, 8'hC3);
    step("rst_hold", 32'hFFFFFFFC, 8'h5A, 1'b1);

    set_in(0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'hC3);
    rst = 1'b0;
    step("fetch0", 32'h00000000, 8'h5A, 1'b1);
    step("fetch1", 32'h00000004, 8'h5A, 1'b1);
    step("fetch2", 32'h00000008, 8'h5A, 1'b1);

    set_in(0, 0, 1, 0, 0, 8'h02, 1, 0, 8'h5A, 8'hC3);
    step("jump_fwd", 32'h00000014, 8'h5A, 1'b1);
    set_in(0, 0, 1, 0, 0, 8'hFE, 1, 0, 8'h5A, 8'hC3);
    step("jump_back", 32'h00000010, 8'h5A, 1'b1);

    set_in(0, 0, 0, 1, 0, 8'h03, 1, 0, 8'h5A, 8'hC3);
    step("beq_not_taken", 32'h00000014, 8'h5A, 1'b1);
    set_in(0, 0, 0, 1, 1, 8'h03, 1, 0, 8'h5A, 8'hC3);
    step("beq_taken", 32'h00000024, 8'h5A, 1'b1);
    set_in(0, 0, 1, 1, 0, 8'h01, 1, 0, 8'h5A, 8'hC3);
    step("jump_and_beq", 32'h0000002C, 8'h5A, 1'b1);

    set_in(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'hC3);
    step("busy1", 32'h0000002C, 8'h5A, 1'b0);
    step("busy2", 32'h0000002C, 8'h5A, 1'b0);
    set_in(0, 1, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'hC3);
    step("ibusy", 32'h0000002C, 8'h5A, 1'b0);
    set_in(0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'hC3);
    step("stall_release", 32'h00000030, 8'h5A, 1'b1);

    set_in(1, 0, 1, 0, 0, 8'h02, 1, 0, 8'h5A, 8'hC3);
    step("stalled_jump", 32'h00000030, 8'h5A, 1'b0);
    set_in(0, 0, 1, 0, 0, 8'h02, 1, 0, 8'h5A, 8'hC3);
    step("jump_retry", 32'h0000003C, 8'h5A, 1'b1);

    set_in(0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h5A, 8'hC3);
    step("wsel_alu", 32'h00000040, 8'h5A, 1'b1);
    set_in(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h5A, 8'hC3);
    step("wsel_mem", 32'h00000044, 8'hC3, 1'b1);

    set_in(0, 0, 1, 0, 0, 8'hEC, 1, 1, 8'h5A, 8'hC3);
    step("jump_to_top", 32'hFFFFFFF8, 8'hC3, 1'b1);
    set_in(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h5A, 8'hC3);
    step("near_wrap", 32'hFFFFFFFC, 8'hC3, 1'b1);
    step("wrap", 32'h00000000, 8'hC3, 1'b1);

    set_in(0, 0, 1, 0, 0, 8'h02, 0, 0, 8'h11, 8'h22);
    rst = 1'b1;
    #1;
    expect_now("mid_reset", 32'hFFFFFFFC, 8'h11, 1'b0);
    step("mid_reset_edge", 32'hFFFFFFFC, 8'h11, 1'b0);
    set_in(1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h11, 8'h22);
    rst = 1'b0;
    step("stall_after_reset", 32'hFFFFFFFC, 8'h22, 1'b0);
    set_in(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h11, 8'h22);
    step("first_after_reset", 32'h00000000, 8'h22, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    if (exp_pc_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_pc_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
